// File: rtl/fifo_axis_arb_pkg.sv
// Shared constants for the FIFO-to-AXIS packet arbiter: state codes, FIFO word field offsets,
// and the index-width helper.
package fifo_axis_arb_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // FIFO word layout is {tuser, tlast, tdata}; the flags sit directly above tdata.
  localparam int TDATA_LSB = 0;
  localparam int TLAST_OFS = 0;
  localparam int TUSER_OFS = 1;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_axis_packet_arbiter_if.sv
// AXI-Stream master bundle driven by fifo_axis_packet_arbiter.
// FIFO_AXIS_ARB_TDEST_EN adds o_axis_tdest carrying the source index.
interface fifo_axis_packet_arbiter_if #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int SRC_IDX_WIDTH   = 2
);
  logic [AXIS_DATA_WIDTH-1:0] o_axis_tdata;
  logic                       o_axis_tuser;
  logic                       o_axis_tlast;
  logic                       o_axis_tvalid;
  logic                       i_axis_tready;
`ifdef FIFO_AXIS_ARB_TDEST_EN
  logic [SRC_IDX_WIDTH-1:0]   o_axis_tdest;
`endif

  modport master (
`ifdef FIFO_AXIS_ARB_TDEST_EN
    output o_axis_tdest,
`endif
    output o_axis_tdata, o_axis_tuser, o_axis_tlast, o_axis_tvalid,
    input  i_axis_tready
  );

  modport slave (
`ifdef FIFO_AXIS_ARB_TDEST_EN
    input  o_axis_tdest,
`endif
    input  o_axis_tdata, o_axis_tuser, o_axis_tlast, o_axis_tvalid,
    output i_axis_tready
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after last_grant, wrapping.
module rr_arbiter
  import fifo_axis_arb_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int IDX_W       = clog2_min1(NUM_SOURCES)
) (
  input  logic [NUM_SOURCES-1:0] req_i,
  input  logic [IDX_W-1:0]       last_grant_i,
  output logic                   found_o,
  output logic [IDX_W-1:0]       grant_idx_o
);

  logic             hit;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the block can infer a latch.
    hit  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = 1; i <= NUM_SOURCES; i++) begin
      cand = IDX_W'((int'(last_grant_i) + i) % NUM_SOURCES);
      if (!hit && req_i[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
  end

  assign found_o     = hit;
  assign grant_idx_o = idx;

endmodule

// File: rtl/fifo_axis_packet_arbiter.sv
// Packet-granular round-robin arbiter merging FIFO read ports onto one registered AXIS master.
// Define FIFO_AXIS_ARB_TDEST_EN to also drive o_axis_tdest with the granted source index.
module fifo_axis_packet_arbiter
  import fifo_axis_arb_pkg::*;
#(
  parameter int NUM_SOURCES     = 4,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int FIFO_DATA_WIDTH = AXIS_DATA_WIDTH + 2,
  parameter int SRC_IDX_WIDTH   = clog2_min1(NUM_SOURCES)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_SOURCES*FIFO_DATA_WIDTH-1:0] i_fifo_data,
  input  logic [NUM_SOURCES-1:0]                 i_fifo_not_empty,
  output logic [NUM_SOURCES-1:0]                 o_fifo_r_stb,
  fifo_axis_packet_arbiter_if.master             m_axis,
  output logic                                   o_busy,
  output logic [SRC_IDX_WIDTH-1:0]               o_grant_idx
);

  logic [0:0]                 state_q, state_d;
  logic [SRC_IDX_WIDTH-1:0]   grant_q, grant_d;
  logic [SRC_IDX_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic                       tvalid_q, tvalid_d;
  logic [AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                       tuser_q, tuser_d;
  logic                       tlast_q, tlast_d;
`ifdef FIFO_AXIS_ARB_TDEST_EN
  logic [SRC_IDX_WIDTH-1:0]   tdest_q, tdest_d;
`endif

  logic [FIFO_DATA_WIDTH-1:0] fifo_word [NUM_SOURCES];
  logic [FIFO_DATA_WIDTH-1:0] sel_word;
  logic                       sel_last;
  logic                       load;
  logic                       arb_found;
  logic [SRC_IDX_WIDTH-1:0]   arb_idx;

  for (genvar k = 0; k < NUM_SOURCES; k++) begin : g_unpack
    assign fifo_word[k] = i_fifo_data[k*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
  end

  assign sel_word = fifo_word[grant_q];
  assign sel_last = sel_word[AXIS_DATA_WIDTH + TLAST_OFS];

  // A pop happens only while granted, the output slot is free or draining, and the FIFO has data.
  assign load = (state_q == ST_GRANT) && (!tvalid_q || m_axis.i_axis_tready)
                && i_fifo_not_empty[grant_q];

  rr_arbiter #(
    .NUM_SOURCES (NUM_SOURCES),
    .IDX_W       (SRC_IDX_WIDTH)
  ) u_rr_arbiter (
    .req_i        (i_fifo_not_empty),
    .last_grant_i (last_grant_q),
    .found_o      (arb_found),
    .grant_idx_o  (arb_idx)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          state_d      = ST_GRANT;
          grant_d      = arb_idx;
          last_grant_d = arb_idx;
        end
      end
      ST_GRANT: begin
        if (load && sel_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The output register drains on its own; IDLE may re-arbitrate while a beat is still pending.
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
`ifdef FIFO_AXIS_ARB_TDEST_EN
    tdest_d  = tdest_q;
`endif
    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = sel_word[TDATA_LSB +: AXIS_DATA_WIDTH];
      tuser_d  = sel_word[AXIS_DATA_WIDTH + TUSER_OFS];
      tlast_d  = sel_last;
`ifdef FIFO_AXIS_ARB_TDEST_EN
      tdest_d  = grant_q;
`endif
    end else if (m_axis.i_axis_tready && tvalid_q) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= SRC_IDX_WIDTH'(NUM_SOURCES - 1);
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tuser_q      <= 1'b0;
      tlast_q      <= 1'b0;
`ifdef FIFO_AXIS_ARB_TDEST_EN
      tdest_q      <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      tuser_q      <= tuser_d;
      tlast_q      <= tlast_d;
`ifdef FIFO_AXIS_ARB_TDEST_EN
      tdest_q      <= tdest_d;
`endif
    end
  end

  assign o_fifo_r_stb         = load ? (NUM_SOURCES'(1) << grant_q) : '0;
  assign o_busy               = (state_q == ST_GRANT);
  assign o_grant_idx          = grant_q;
  assign m_axis.o_axis_tvalid = tvalid_q;
  assign m_axis.o_axis_tdata  = tdata_q;
  assign m_axis.o_axis_tuser  = tuser_q;
  assign m_axis.o_axis_tlast  = tlast_q;
`ifdef FIFO_AXIS_ARB_TDEST_EN
  assign m_axis.o_axis_tdest  = tdest_q;
`endif

endmodule

// File: tb/tb_fifo_axis_packet_arbiter.sv
// Self-checking bench: queue-based FIFOs and a packet-level reference model of the arbiter.
module tb_fifo_axis_packet_arbiter;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int FW = DW + 2;
  localparam int IW = 2;

  typedef logic [FW-1:0] word_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NS*FW-1:0] fifo_data;
  logic [NS-1:0]   fifo_ne;
  logic [NS-1:0]   r_stb;
  logic            busy;
  logic [IW-1:0]   grant_idx;

  fifo_axis_packet_arbiter_if #(.AXIS_DATA_WIDTH(DW), .SRC_IDX_WIDTH(IW)) axis_if ();

  fifo_axis_packet_arbiter #(
    .NUM_SOURCES     (NS),
    .AXIS_DATA_WIDTH (DW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_fifo_data      (fifo_data),
    .i_fifo_not_empty (fifo_ne),
    .o_fifo_r_stb     (r_stb),
    .m_axis           (axis_if),
    .o_busy           (busy),
    .o_grant_idx      (grant_idx)
  );

  always #5 clk = ~clk;

  // Source FIFOs, the model's one-entry output slot, and the log of delivered beats.
  word_t fq [NS][$];
  word_t out_q [$];
  word_t dlv_w [$];
  int    dlv_cyc [$];
  logic  tready_pat [$];
  logic  m_busy;
  int    m_owner;
  int    m_last;
  int    pops [NS];
  int    cyc;
  int    tready_mode;
  int    n_checks;
  int    n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    out_q.delete();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = NS - 1;
  endtask

  task automatic clear_log();
    dlv_w.delete();
    dlv_cyc.delete();
    for (int k = 0; k < NS; k++) pops[k] = 0;
  endtask

  task automatic push_pkt(input int src, input int len, input logic [31:0] base, input logic tuser);
    for (int j = 0; j < len; j++) fq[src].push_back({tuser, (j == len - 1), base + 32'(j)});
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < NS; k++) begin
      if (fq[k].size() != 0) begin
        fifo_ne[k] = 1'b1;
        fifo_data[k*FW +: FW] = fq[k][0];
      end else begin
        fifo_ne[k] = 1'b0;
        fifo_data[k*FW +: FW] = '0;
      end
    end
    if (tready_pat.size() != 0) axis_if.i_axis_tready = tready_pat.pop_front();
    else if (tready_mode == 1) axis_if.i_axis_tready = ($urandom_range(0, 3) != 0);
    else axis_if.i_axis_tready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_tvalid"}, axis_if.o_axis_tvalid, 0);
    check({pfx, "_r_stb"}, r_stb, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_grant_idx"}, grant_idx, 0);
    check({pfx, "_tdata"}, axis_if.o_axis_tdata, 0);
    check({pfx, "_tlast_tuser"}, {axis_if.o_axis_tlast, axis_if.o_axis_tuser}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive_inputs();
  endtask

  // One clock: drive inputs, compare the DUT with the model, then advance the model across the edge.
  task automatic tick();
    logic [NS-1:0] exp_stb;
    logic          rdy;
    logic          found;
    word_t         w;
    int            k;
    @(negedge clk);
    drive_inputs();
    #1;
    cyc++;
    rdy = axis_if.i_axis_tready;
    exp_stb = '0;
    if (m_busy && (out_q.size() == 0 || rdy) && fq[m_owner].size() != 0) exp_stb[m_owner] = 1'b1;
    check("r_stb", r_stb, exp_stb);
    check("tvalid", axis_if.o_axis_tvalid, out_q.size() != 0);
    if (out_q.size() != 0)
      check("beat", {axis_if.o_axis_tuser, axis_if.o_axis_tlast, axis_if.o_axis_tdata}, out_q[0]);
    check("busy", busy, m_busy);
    check("grant_idx", grant_idx, m_owner);

    if (out_q.size() != 0 && rdy) begin
      dlv_w.push_back(out_q.pop_front());
      dlv_cyc.push_back(cyc);
    end
    if (exp_stb != '0) begin
      w = fq[m_owner].pop_front();
      pops[m_owner]++;
      out_q.push_back(w);
      if (w[FW-2]) m_busy = 1'b0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int i = 1; i <= NS; i++) begin
        k = (m_last + i) % NS;
        if (!found && fq[k].size() != 0) begin
          found   = 1'b1;
          m_owner = k;
          m_last  = k;
          m_busy  = 1'b1;
        end
      end
    end
  endtask

  function automatic logic all_idle();
    logic e;
    e = (out_q.size() == 0) && !m_busy;
    for (int k = 0; k < NS; k++) if (fq[k].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", all_idle(), 1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    int total;
    int s;
    int len;
    n_checks = 0;
    n_pass = 0;
    cyc = 0;
    tready_mode = 0;
    fifo_ne = '0;
    fifo_data = '0;
    axis_if.i_axis_tready = 1'b1;
    model_reset();
    clear_log();

    // Single packet from source 0.
    do_reset();
    push_pkt(0, 3, 32'hA0, 1'b0);
    t0 = cyc + 1;
    drain(50);
    check("sp_beats", dlv_w.size(), 3);
    check("sp_pops0", pops[0], 3);
    check("sp_pops_other", pops[1] + pops[2] + pops[3], 0);
    if (dlv_w.size() == 3) begin
      check("sp_latency", dlv_cyc[0] - t0, 2);
      check("sp_back_to_back", dlv_cyc[2] - dlv_cyc[0], 2);
      check("sp_tlast_beat3", dlv_w[2][FW-2], 1);
      check("sp_tlast_beat2", dlv_w[1][FW-2], 0);
      check("sp_data_beat1", dlv_w[0][DW-1:0], 32'hA0);
    end

    // Round robin with all four sources requesting at once.
    do_reset();
    clear_log();
    for (int k = 0; k < NS; k++) push_pkt(k, 2, (32'(k) << 28) | 32'h100, k[0]);
    drain(100);
    check("rr_beats", dlv_w.size(), 8);
    if (dlv_w.size() == 8) begin
      for (int p = 0; p < NS; p++) check("rr_order", dlv_w[2*p][31:28], p);
      for (int p = 0; p < NS - 1; p++) check("rr_bubble", dlv_cyc[2*p+2] - dlv_cyc[2*p+1], 2);
    end

    // Fairness wrap: src3 was served last, so src1 wins over src3.
    clear_log();
    push_pkt(3, 1, 32'h3000_0000, 1'b0);
    push_pkt(1, 1, 32'h1000_0000, 1'b0);
    drain(50);
    check("fair_beats", dlv_w.size(), 2);
    if (dlv_w.size() == 2) begin
      check("fair_first", dlv_w[0][31:28], 1);
      check("fair_second", dlv_w[1][31:28], 3);
    end

    // Backpressure mid-packet.
    clear_log();
    tready_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    push_pkt(1, 4, 32'h1000_0200, 1'b1);
    drain(50);
    check("bp_beats", dlv_w.size(), 4);
    check("bp_pops1", pops[1], 4);
    if (dlv_w.size() == 4)
      for (int j = 0; j < 4; j++) check("bp_data", dlv_w[j][27:0], 28'h200 + 28'(j));

    // Granted source starves mid-packet while another requests.
    do_reset();
    clear_log();
    fq[2].push_back({1'b0, 1'b0, 32'h2000_0000});
    repeat (3) tick();
    push_pkt(0, 2, 32'h0000_0300, 1'b0);
    repeat (5) tick();
    check("st_busy", busy, 1);
    check("st_grant", grant_idx, 2);
    check("st_src0_pops", pops[0], 0);
    for (int j = 1; j <= 3; j++) fq[2].push_back({1'b0, (j == 3), 32'h2000_0000 + 32'(j)});
    drain(100);
    check("st_beats", dlv_w.size(), 6);
    if (dlv_w.size() == 6) begin
      check("st_tail_src", dlv_w[3][31:28], 2);
      check("st_next_src", dlv_w[4][31:28], 0);
    end

    // Asynchronous reset while beat 2 is presented.
    clear_log();
    push_pkt(1, 4, 32'h1000_0400, 1'b0);
    n = 0;
    while (dlv_w.size() < 1 && n < 30) begin
      tick();
      n++;
    end
    check("mr_reached", dlv_w.size(), 1);
    @(posedge clk);
    #2;
    check("mr_pre_tvalid", axis_if.o_axis_tvalid, 1);
    check("mr_pre_tdata", axis_if.o_axis_tdata, 32'h1000_0401);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mr");
    model_reset();
    fq[1].delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive_inputs();
    clear_log();
    push_pkt(2, 1, 32'h2000_0500, 1'b0);
    push_pkt(0, 1, 32'h0000_0500, 1'b0);
    drain(50);
    check("mr_after_beats", dlv_w.size(), 2);
    if (dlv_w.size() == 2) check("mr_after_first", dlv_w[0][31:28], 0);

    // Randomized traffic with random backpressure.
    tready_mode = 1;
    for (int r = 0; r < 4; r++) begin
      clear_log();
      total = 0;
      for (int p = 0; p < 12; p++) begin
        s   = $urandom_range(0, NS - 1);
        len = $urandom_range(1, 4);
        push_pkt(s, len, {4'(s), 28'($urandom)}, 1'($urandom));
        total += len;
        repeat ($urandom_range(0, 3)) tick();
      end
      drain(2000);
      check("rnd_beats", dlv_w.size(), total);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_axis_packet_arbiter.md
Name: fifo_axis_packet_arbiter

Overview:
- Shares one AXI-Stream master between NUM_SOURCES FIFO read ports. Each FIFO word is packed as {tuser, tlast, tdata}.
- Round-robin arbitration at packet granularity. A grant is held until the beat with tlast=1 has been popped.
- Output beat is registered: one-entry pipeline stage, full throughput.
- Sits between the per-channel capture FIFOs and the single downstream AXIS sink (DMA/host bridge).

Parameters:
- NUM_SOURCES, 4, number of FIFO requesters (2..16).
- AXIS_DATA_WIDTH, 32, tdata width.
- FIFO_DATA_WIDTH, AXIS_DATA_WIDTH+2, packed FIFO word: bit W-1 = tuser, bit W-2 = tlast, bits W-3:0 = tdata.
- SRC_IDX_WIDTH, clog2(NUM_SOURCES) (min 1), width of source index.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_fifo_data  in  NUM_SOURCES*FIFO_DATA_WIDTH  flattened FIFO read data; source k occupies slice k.
- i_fifo_not_empty  in  NUM_SOURCES  per-source FIFO has data.
- o_fifo_r_stb  out  NUM_SOURCES  per-source pop strobe, one-hot or zero.
- o_axis_tuser  out  1  registered tuser.
- o_axis_tdata  out  AXIS_DATA_WIDTH  registered tdata.
- o_axis_tvalid  out  1  output beat valid.
- i_axis_tready  in  1  sink ready.
- o_axis_tlast  out  1  registered tlast.
- o_busy  out  1  a grant is held (state GRANT).
- o_grant_idx  out  SRC_IDX_WIDTH  currently/last granted source.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, o_axis_tvalid=0, tdata/tuser/tlast=0, o_fifo_r_stb=0, o_busy=0, o_grant_idx=0. Round-robin pointer last_grant=NUM_SOURCES-1, so source 0 has first priority.
- States are IDLE and GRANT.
- IDLE:
  - If any i_fifo_not_empty: pick the first requester strictly after last_grant (wrapping), register it in o_grant_idx/last_grant, and go to GRANT next edge.
  - No pop occurs in IDLE.
- GRANT, load condition = (!o_axis_tvalid || i_axis_tready) && i_fifo_not_empty[g]:
  - o_fifo_r_stb[g]=1 combinationally.
  - Output registers load slice g and o_axis_tvalid=1 at the next edge.
- Else, if i_axis_tready && o_axis_tvalid: o_axis_tvalid clears at the next edge.
- Popped beat has tlast=1: state returns to IDLE at the same edge. The beat in the output register drains independently; IDLE may re-arbitrate while it is still pending.
- Latency: not_empty asserted in IDLE cycle N → pop in cycle N+1 → tvalid at N+2. Thereafter 1 beat/cycle while tready=1 and the FIFO is non-empty. There is one IDLE cycle bubble between packets.
- Granted FIFO empties mid-packet: grant is held, no switch, tvalid drops after drain. Pops resume when not_empty returns.
- tready=0 with tvalid=1: output registers stable (AXIS rule), no pops.
- Requests from non-granted sources have no effect in GRANT.
- Only one source requesting: it wins every arbitration.
- Reset mid-packet: partial packet discarded, all state cleared. The FIFO remainder is the source's responsibility.
- o_fifo_r_stb is never asserted for a source with not_empty=0.

Optional Feature:
- Macro FIFO_AXIS_ARB_TDEST_EN.
- Defined: adds output port o_axis_tdest [SRC_IDX_WIDTH-1:0]. It is registered alongside tdata with the granted index, reset 0, and held while tvalid && !tready.
- Undefined: port absent; source identity is available only via o_grant_idx.

Decomposition:
- Package fifo_axis_arb_pkg:
  - state enum (IDLE, GRANT);
  - field-offset localparams for tuser/tlast/tdata within the FIFO word;
  - clog2 helper function.
- Sub-module rr_arbiter (combinational): inputs req[NUM_SOURCES] and last_grant; outputs found and grant_idx. Instantiated once.

Test Plan:
- Single packet: src0 holds 3 words (0xA0, 0xA1, 0xA2 with tlast), tready=1 → tvalid high for 3 consecutive cycles starting 2 cycles after not_empty; exactly 3 pops on o_fifo_r_stb[0]; tlast on the third beat.
- Round robin: src0..3 each hold one 2-beat packet, all requesting at once → output order src0, src1, src2, src3; exactly one idle bubble between packets; o_grant_idx tracks.
- Fairness wrap: after src3 is served, src3 and src1 both request → src1 is granted before src3 is re-served.
- Backpressure: tready toggles 1,0,0,1 mid-packet → data stable while stalled, no pops while tvalid && !tready, no beat lost or duplicated.
- Mid-packet starvation: src2 empties after beat 1 of 4 while src0 requests → grant stays on src2; src0 is not served until src2's tlast beat is popped.
- Async reset mid-packet: rst_n=0 during beat 2 → tvalid, r_stb and busy go 0 immediately; after release, src0 has priority.
